// File: rtl/noc_pkg.sv
// Shared NoC types and helpers: 1-of-4 decode, flit record and default synchroniser depth.
package noc_pkg;

    localparam int unsigned NSYNC_DEF = 2;
    localparam int unsigned DW_DEF    = 16;

    typedef struct packed {
        logic              eof;
        logic [DW_DEF-1:0] data;
    } flit_t;

    // Lowest asserted rail wins, so multi-hot codes still decode deterministically.
    function automatic logic [1:0] dec1of4(input logic [3:0] r);
        if (r[0])      return 2'd0;
        else if (r[1]) return 2'd1;
        else if (r[2]) return 2'd2;
        else if (r[3]) return 2'd3;
        else           return 2'd0;
    endfunction

endpackage

// File: rtl/ni_fifo.sv
// Synchronous flit FIFO with a registered head; occupancy counts the head plus stored entries.
module ni_fifo #(
    parameter int unsigned W  = 17,
    parameter int unsigned FD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         vld,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = (FD > 1) ? $clog2(FD) : 1;
    localparam int unsigned CW = $clog2(FD) + 1;

    logic [W-1:0]  mem [FD];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] mem_cnt;
    logic          head_vld;
    logic [W-1:0]  head_q;
    logic          push_ok, pop_ok, load;

    // Full ignores a same-cycle pop, so a pop never frees a slot for a push on the same edge.
    assign full    = (mem_cnt + CW'(head_vld)) == CW'(FD);
    assign empty   = ~head_vld && (mem_cnt == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & head_vld;
    assign load    = (mem_cnt != '0) && (~head_vld || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            head_vld <= 1'b0;
            head_q   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                head_q   <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
                head_vld <= 1'b1;
            end else if (pop_ok) begin
                head_vld <= 1'b0;
            end
            mem_cnt <= mem_cnt + CW'(push_ok) - CW'(load);
        end
    end

    assign rdata = head_q;
    assign vld   = head_vld;

endmodule

// File: rtl/ni_rx_sync.sv
// NI receiver: synchronises 1-of-4 QDI rails into clk, decodes tokens, queues flits, drives 4-phase ack.
module ni_rx_sync
    import noc_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned SCN   = DW / 2,
    parameter int unsigned FD    = 4,
    parameter int unsigned NSYNC = NSYNC_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [SCN-1:0] i0,
    input  logic [SCN-1:0] i1,
    input  logic [SCN-1:0] i2,
    input  logic [SCN-1:0] i3,
    input  logic           i4,
    output logic           ia,
    output logic [DW-1:0]  dout,
    output logic           dout_eof,
    output logic           dout_vld,
    input  logic           dout_rdy,
    output logic           err
);

    localparam int unsigned RW = 4 * SCN + 1;

    typedef enum logic {IDLE, ACK} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rails;
    logic [RW-1:0] sync_q [NSYNC];
    logic [SCN-1:0] s0, s1, s2, s3;
    logic          s4;
    logic [3:0]    code;
    logic          all_coded, data_any, multi;
    logic          data_done, eof_done, null_tok, illegal;
    logic [DW-1:0] dec;
    logic          push, full, empty;
    logic          err_q;
    logic [DW:0]   wflit, hflit;

    assign rails = {i4, i3, i2, i1, i0};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NSYNC; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rails;
            for (int unsigned i = 1; i < NSYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign {s4, s3, s2, s1, s0} = sync_q[NSYNC-1];

    always_comb begin
        all_coded = 1'b1;
        data_any  = 1'b0;
        multi     = 1'b0;
        dec       = '0;
        code      = '0;
        for (int unsigned j = 0; j < SCN; j++) begin
            code = {s3[j], s2[j], s1[j], s0[j]};
            if (code == '0) all_coded = 1'b0;
            else            data_any  = 1'b1;
            if ((code & (code - 4'd1)) != '0) multi = 1'b1;
            dec[2*j +: 2] = dec1of4(code);
        end
    end

    // An eof rail alongside complete data is illegal but still completes, as a data flit.
    assign data_done = all_coded;
    assign eof_done  = s4 & ~data_any;
    assign null_tok  = ~s4 & ~data_any;
    assign illegal   = multi | (s4 & data_any);
    assign wflit     = {eof_done, dec};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_q | illegal;
        end
    end

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if ((data_done | eof_done) && !full) begin
                    push    = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (null_tok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    ni_fifo #(
        .W  (DW + 1),
        .FD (FD)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wflit),
        .pop   (dout_rdy),
        .rdata (hflit),
        .vld   (dout_vld),
        .full  (full),
        .empty (empty)
    );

    assign ia       = (state_q == ACK);
    assign dout     = hflit[DW-1:0];
    assign dout_eof = hflit[DW];
    assign err      = err_q;

endmodule

// File: tb/tb_ni_rx_sync.sv
// Directed bench for ni_rx_sync (DW=16, NSYNC=2, FD=4): table of tokens plus handshake corner sequences.
module tb_ni_rx_sync;

    localparam int DW  = 16;
    localparam int SCN = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [SCN-1:0] i0, i1, i2, i3;
    logic           i4;
    logic           ia, dout_eof, dout_vld, dout_rdy, err;
    logic [DW-1:0]  dout;

    int errors = 0;
    int checks = 0;

    ni_rx_sync #(
        .DW    (DW),
        .FD    (4),
        .NSYNC (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i0       (i0),
        .i1       (i1),
        .i2       (i2),
        .i3       (i3),
        .i4       (i4),
        .ia       (ia),
        .dout     (dout),
        .dout_eof (dout_eof),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rails;
        logic        r4;
        logic [15:0] exp_dout;
        logic        exp_eof;
        logic        exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Encodes each 2-bit group of d as a one-hot rail; result is {i3,i2,i1,i0}.
    function automatic logic [31:0] enc(input logic [15:0] d);
        logic [7:0] r [4];
        logic [1:0] v;
        for (int k = 0; k < 4; k++) r[k] = '0;
        for (int j = 0; j < 8; j++) begin
            v = d[2*j +: 2];
            r[v][j] = 1'b1;
        end
        return {r[3], r[2], r[1], r[0]};
    endfunction

    task automatic set_rails(input logic [31:0] r, input logic e);
        {i3, i2, i1, i0} = r;
        i4 = e;
    endtask

    task automatic wait_ia(input logic v, input string name);
        int n = 0;
        while (ia !== v && n < 20) begin
            tick();
            n++;
        end
        chk(name, {31'b0, ia}, {31'b0, v});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ill;

        tbl[0] = '{"tok_a5c3", enc(16'hA5C3), 1'b0, 16'hA5C3, 1'b0, 1'b0};
        tbl[1] = '{"tok_eof",  32'h0,         1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{"tok_0000", enc(16'h0000), 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[3] = '{"tok_ffff", enc(16'hFFFF), 1'b0, 16'hFFFF, 1'b0, 1'b0};
        tbl[4] = '{"tok_1234", enc(16'h1234), 1'b0, 16'h1234, 1'b0, 1'b0};
        ill = enc(16'h00FF);
        ill[24+3] = 1'b0;     // i3[3] off
        ill[0+3]  = 1'b1;     // i0[3] on
        ill[8+3]  = 1'b1;     // i1[3] on
        tbl[5] = '{"tok_illegal", ill, 1'b0, 16'h003F, 1'b0, 1'b1};

        rst      = 1'b1;
        dout_rdy = 1'b0;
        set_rails('0, 1'b0);

        // Reset and idle
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("rst_ia",   {31'b0, ia},       32'd0);
            chk("rst_vld",  {31'b0, dout_vld}, 32'd0);
            chk("rst_err",  {31'b0, err},      32'd0);
            chk("rst_dout", {16'b0, dout},     32'd0);
            chk("rst_eof",  {31'b0, dout_eof}, 32'd0);
            tick();
        end

        // Back-pressure: four fill the FIFO, fifth waits for a pop
        for (int k = 1; k <= 4; k++) begin
            set_rails(enc(16'(k)), 1'b0);
            wait_ia(1'b1, "fill_ia_rise");
            set_rails('0, 1'b0);
            wait_ia(1'b0, "fill_ia_fall");
        end
        chk("fill_vld",  {31'b0, dout_vld}, 32'd1);
        chk("fill_head", {16'b0, dout},     32'h0001);
        set_rails(enc(16'h0005), 1'b0);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("full_hold_ia", {31'b0, ia}, 32'd0);
        end
        dout_rdy = 1'b1;
        tick();
        dout_rdy = 1'b0;
        chk("pop_next_head", {16'b0, dout}, 32'h0002);
        chk("pop_edge_ia",   {31'b0, ia},   32'd0);
        tick();
        chk("fifth_ia", {31'b0, ia}, 32'd1);
        set_rails('0, 1'b0);
        wait_ia(1'b0, "fifth_ia_fall");
        for (int k = 2; k <= 5; k++) begin
            chk("drain_vld",  {31'b0, dout_vld}, 32'd1);
            chk("drain_dout", {16'b0, dout},     32'(k));
            dout_rdy = 1'b1;
            tick();
            dout_rdy = 1'b0;
        end
        chk("drain_empty", {31'b0, dout_vld}, 32'd0);
        chk("drain_hold",  {16'b0, dout},     32'h0005);
        tick();

        // Table: each token with exact 4-phase timing
        foreach (tbl[n]) begin
            set_rails(tbl[n].rails, tbl[n].r4);
            tick();
            tick();
            chk({tbl[n].name, "_ia_early"}, {31'b0, ia}, 32'd0);
            tick();
            chk({tbl[n].name, "_ia_rise"},  {31'b0, ia},       32'd1);
            chk({tbl[n].name, "_vld_early"}, {31'b0, dout_vld}, 32'd0);
            tick();
            chk({tbl[n].name, "_vld"},  {31'b0, dout_vld}, 32'd1);
            chk({tbl[n].name, "_dout"}, {16'b0, dout},     {16'b0, tbl[n].exp_dout});
            chk({tbl[n].name, "_eof"},  {31'b0, dout_eof}, {31'b0, tbl[n].exp_eof});
            chk({tbl[n].name, "_err"},  {31'b0, err},      {31'b0, tbl[n].exp_err});
            set_rails('0, 1'b0);
            tick();
            tick();
            chk({tbl[n].name, "_ia_held"}, {31'b0, ia}, 32'd1);
            tick();
            chk({tbl[n].name, "_ia_fall"}, {31'b0, ia}, 32'd0);
            dout_rdy = 1'b1;
            tick();
            dout_rdy = 1'b0;
            chk({tbl[n].name, "_popped"}, {31'b0, dout_vld}, 32'd0);
            chk({tbl[n].name, "_hold"},   {16'b0, dout},     {16'b0, tbl[n].exp_dout});
        end
        chk("err_sticky", {31'b0, err}, 32'd1);

        // Reset while acknowledging; held rails are captured again afterwards
        set_rails(enc(16'hBEEF), 1'b0);
        wait_ia(1'b1, "midack_ia_rise");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midack_ia",  {31'b0, ia},       32'd0);
        chk("midack_vld", {31'b0, dout_vld}, 32'd0);
        chk("midack_err", {31'b0, err},      32'd0);
        tick();
        tick();
        chk("recap_ia_early", {31'b0, ia}, 32'd0);
        tick();
        chk("recap_ia", {31'b0, ia}, 32'd1);
        tick();
        chk("recap_vld",  {31'b0, dout_vld}, 32'd1);
        chk("recap_dout", {16'b0, dout},     32'h0000BEEF);
        set_rails('0, 1'b0);
        wait_ia(1'b0, "recap_ia_fall");
        dout_rdy = 1'b1;
        tick();
        dout_rdy = 1'b0;
        chk("recap_popped", {31'b0, dout_vld}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
